// File: rtl/tuple_hash_if.sv
// Tuple bus between the ingest source, the hash stage and the distributors.
// The slave side is the hash stage: it consumes in_* and produces out_*.
interface tuple_hash_if #(
  parameter int INPUT_SIZE = 64,
  parameter int TAG_WIDTH  = 32
);
  logic                  in_ready;
  logic                  in_valid;
  logic [INPUT_SIZE-1:0] in_data;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  in_last;
  logic                  out_ready;
  logic                  out_valid;
  logic [INPUT_SIZE-1:0] out_data;
  logic [63:0]           out_hash;
  logic [TAG_WIDTH-1:0]  out_tag;
  logic                  out_last_processed;
  logic [63:0]           out_serialnum;
  logic                  out_was_joined;

  modport slave (
    output in_ready,
    input  in_valid, in_data, in_tag, in_last,
    input  out_ready,
    output out_valid, out_data, out_hash, out_tag,
    output out_last_processed, out_serialnum, out_was_joined
  );

  modport master (
    input  in_ready,
    output in_valid, in_data, in_tag, in_last,
    output out_ready,
    input  out_valid, out_data, out_hash, out_tag,
    input  out_last_processed, out_serialnum, out_was_joined
  );
endinterface

// File: rtl/tuple_hash_stage.sv
// Ingest stage: fmix64 digest of the 64-bit key, per-stream serial stamping,
// 3-deep stallable pipeline. Each stage carries its own valid bit and the
// tuple sideband; the digest is refined one fmix64 step per stage.
module tuple_hash_stage #(
  parameter int INPUT_SIZE = 64,
  parameter int TAG_WIDTH  = 32
) (
  input logic         clk,
  input logic         reset,
  tuple_hash_if.slave bus
);

  localparam logic [63:0] MIX_C1 = 64'hFF51_AFD7_ED55_8CCD;
  localparam logic [63:0] MIX_C2 = 64'hC4CE_B9FE_1A85_EC53;

  typedef struct packed {
    logic [INPUT_SIZE-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;
    logic                  last;
    logic [63:0]           serial;
    logic [63:0]           hash;
  } stage_t;

  // xor-shift step shared by all three fmix64 rounds
  function automatic logic [63:0] xs33(input logic [63:0] x);
    return x ^ (x >> 6'd33);
  endfunction

  logic        v1_q, v2_q, v3_q;
  logic        v1_d, v2_d, v3_d;
  stage_t      s1_q, s2_q, s3_q;
  stage_t      s1_d, s2_d, s3_d;
  logic [63:0] serial_q, serial_d;

  logic ld1, ld2, ld3;
  logic in_ready_c;
  logic in_xfer;

  // Backpressure chain: a stage may load when empty or when its successor loads.
  always_comb begin
    ld3        = ~v3_q | bus.out_ready;
    ld2        = ~v2_q | ld3;
    ld1        = ~v1_q | ld2;
    in_ready_c = ~reset & ld1;
    in_xfer    = bus.in_valid & in_ready_c;
  end

  // Next state of the three stages and of the per-stream serial counter.
  always_comb begin
    v1_d     = v1_q;
    v2_d     = v2_q;
    v3_d     = v3_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    s3_d     = s3_q;
    serial_d = serial_q;

    if (ld1) begin
      v1_d = in_xfer;
      if (in_xfer) begin
        s1_d.data   = bus.in_data;
        s1_d.tag    = bus.in_tag;
        s1_d.last   = bus.in_last;
        s1_d.serial = serial_q;
        s1_d.hash   = xs33(bus.in_data[63:0]) * MIX_C1;
      end else begin
        s1_d = s1_q;
      end
    end else begin
      v1_d = v1_q;
    end

    if (ld2) begin
      v2_d      = v1_q;
      s2_d      = s1_q;
      s2_d.hash = xs33(s1_q.hash) * MIX_C2;
    end else begin
      v2_d = v2_q;
    end

    if (ld3) begin
      v3_d      = v2_q;
      s3_d      = s2_q;
      s3_d.hash = xs33(s2_q.hash);
    end else begin
      v3_d = v3_q;
    end

    // The value handed to S1 is the pre-increment count; in_last restarts the stream.
    if (in_xfer) begin
      serial_d = bus.in_last ? 64'd0 : serial_q + 64'd1;
    end else begin
      serial_d = serial_q;
    end
  end

  // State registers; reset discards everything in flight and restarts the serial.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      serial_q <= 64'd0;
    end else begin
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      serial_q <= serial_d;
    end
  end

  assign bus.in_ready           = in_ready_c;
  assign bus.out_valid          = v3_q;
  assign bus.out_data           = s3_q.data;
  assign bus.out_hash           = s3_q.hash;
  assign bus.out_tag            = s3_q.tag;
  assign bus.out_last_processed = s3_q.last;
  assign bus.out_serialnum      = s3_q.serial;
  assign bus.out_was_joined     = 1'b0;

endmodule
